// File: rtl/eight_bit_unsigned_sequential_divider_pkg.sv
// Shared types and default widths for the sequential restoring divider.
package divider_pkg;
  localparam int DIVIDEND_W = 16;
  localparam int DIVISOR_W  = 8;
  localparam int CNT_W      = 4;

  typedef enum logic {IDLE, RUN} state_t;
endpackage

// File: rtl/eight_bit_unsigned_sequential_divider_step.sv
// One restoring-division step: shift in a dividend bit, subtract the divisor if it fits.
module div_restoring_step
  import divider_pkg::*;
#(
  parameter int DIVISOR_WIDTH = DIVISOR_W
) (
  input  logic [DIVISOR_WIDTH:0]   rem,
  input  logic                     bit_in,
  input  logic [DIVISOR_WIDTH-1:0] divisor,
  output logic [DIVISOR_WIDTH:0]   rem_next,
  output logic                     q_bit
);
  logic [DIVISOR_WIDTH:0] shifted, diff;
  // partial remainder is always below the divisor, so its MSB never carries information
  logic unused_msb;

  assign unused_msb = rem[DIVISOR_WIDTH];
  assign shifted    = {rem[DIVISOR_WIDTH-1:0], bit_in};
  assign diff       = shifted - {1'b0, divisor};
  assign q_bit      = (shifted >= {1'b0, divisor});
  assign rem_next   = q_bit ? diff : shifted;
endmodule

// File: rtl/eight_bit_unsigned_sequential_divider.sv
// Sequential restoring divider, one quotient bit per clock behind start/busy/done.
// Define DIV_ZERO_FAST_EN to short-circuit divide-by-zero in one cycle and report div_by_zero.
module eight_bit_unsigned_sequential_divider
  import divider_pkg::*;
#(
  parameter int DIVIDEND_WIDTH = DIVIDEND_W,
  parameter int DIVISOR_WIDTH  = DIVISOR_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [DIVIDEND_WIDTH-1:0] dividend,
  input  logic [DIVISOR_WIDTH-1:0]  divisor,
  output logic                      busy,
  output logic                      done,
  output logic [DIVIDEND_WIDTH-1:0] quotient,
  output logic [DIVISOR_WIDTH-1:0]  remainder,
  output logic                      div_by_zero
);
  localparam int CW = $clog2(DIVIDEND_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(DIVIDEND_WIDTH - 1);

  state_t                    state, state_next;
  logic [CW-1:0]             cnt;
  logic [DIVIDEND_WIDTH-1:0] dvd_sh;
  logic [DIVISOR_WIDTH-1:0]  dsr;
  logic [DIVISOR_WIDTH:0]    rem_r, rem_next;
  logic                      q_bit, accept, step, finish_run;
  logic                      zero_pend, fast_zero, dbz_r;

`ifdef DIV_ZERO_FAST_EN
  assign fast_zero = accept && (divisor == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) zero_pend <= 1'b0;
    else        zero_pend <= fast_zero;
  end
`else
  assign fast_zero = 1'b0;
  assign zero_pend = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept && !fast_zero) state_next = RUN;
      RUN:  if (cnt == LAST)          state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // a pending zero-divisor completion keeps the block busy and blocks new starts
  always_comb begin
    accept     = 1'b0;
    step       = 1'b0;
    finish_run = 1'b0;
    busy       = zero_pend;
    case (state)
      IDLE: accept = start && !zero_pend;
      RUN: begin
        busy       = 1'b1;
        step       = 1'b1;
        finish_run = (cnt == LAST);
      end
      default: ;
    endcase
  end

  div_restoring_step #(.DIVISOR_WIDTH(DIVISOR_WIDTH)) u_step (
    .rem      (rem_r),
    .bit_in   (dvd_sh[DIVIDEND_WIDTH-1]),
    .divisor  (dsr),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  // dividend bits leave the MSB while quotient bits enter the LSB of the same register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_sh <= '0;
      dsr    <= '0;
      rem_r  <= '0;
      cnt    <= '0;
    end else if (accept) begin
      dvd_sh <= dividend;
      dsr    <= divisor;
      rem_r  <= '0;
      cnt    <= '0;
    end else if (step) begin
      dvd_sh <= {dvd_sh[DIVIDEND_WIDTH-2:0], q_bit};
      rem_r  <= rem_next;
      cnt    <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      dbz_r     <= 1'b0;
    end else begin
      done <= finish_run || zero_pend;
      if (finish_run) begin
        quotient  <= {dvd_sh[DIVIDEND_WIDTH-2:0], q_bit};
        remainder <= rem_next[DIVISOR_WIDTH-1:0];
        dbz_r     <= 1'b0;
      end else if (zero_pend) begin
        quotient  <= '1;
        remainder <= dvd_sh[DIVISOR_WIDTH-1:0];
        dbz_r     <= 1'b1;
      end
    end
  end

  assign div_by_zero = dbz_r;
endmodule

// File: tb/tb_eight_bit_unsigned_sequential_divider.sv
// Directed bench for the sequential divider: latency, back-to-back, div-by-zero, ignored start, reset.
module tb_eight_bit_unsigned_sequential_divider;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [15:0] dividend = '0;
  logic [7:0]  divisor = '0;
  logic        busy, done, div_by_zero;
  logic [15:0] quotient;
  logic [7:0]  remainder;

  int passed = 0;
  int total  = 0;

  eight_bit_unsigned_sequential_divider dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // counts edges until done is seen, bounded so a dead DUT cannot hang the run
  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!done && n < 40);
  endtask

  task automatic launch(input logic [15:0] a, input logic [7:0] b);
    dividend = a; divisor = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  initial begin
    int n;
    logic seen;

    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_q", quotient, 0);
    chk("rst_r", remainder, 0);
    chk("rst_dbz", div_by_zero, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // 1000 / 7, operands scrambled after the start edge
    launch(16'd1000, 8'd7);
    dividend = 16'hBEEF; divisor = 8'd3;
    chk("t1_busy_e0", busy, 1);
    seen = 1'b0;
    repeat (15) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    chk("t1_no_early_done", seen, 0);
    chk("t1_busy_e15", busy, 1);
    @(posedge clk); #1;
    chk("t1_done_e16", done, 1);
    chk("t1_busy_e16", busy, 0);
    chk("t1_q", quotient, 142);
    chk("t1_r", remainder, 6);
    @(posedge clk); #1;
    chk("t1_done_clr", done, 0);
    chk("t1_q_hold", quotient, 142);

    // max / max, then back-to-back on the done cycle
    launch(16'hFFFF, 8'hFF);
    wait_done(n);
    chk("t2_lat", n, 16);
    chk("t2_q", quotient, 16'h0101);
    chk("t2_r", remainder, 0);
    launch(16'd5, 8'd9);
    chk("t2b_busy", busy, 1);
    wait_done(n);
    chk("t2b_lat", n, 16);
    chk("t2b_q", quotient, 0);
    chk("t2b_r", remainder, 5);

    // divide by zero
    launch(16'h1234, 8'd0);
    chk("t3_busy_e0", busy, 1);
    wait_done(n);
`ifdef DIV_ZERO_FAST_EN
    chk("t3_lat", n, 1);
    chk("t3_dbz", div_by_zero, 1);
`else
    chk("t3_lat", n, 16);
    chk("t3_dbz", div_by_zero, 0);
`endif
    chk("t3_busy_after", busy, 0);
    chk("t3_q", quotient, 16'hFFFF);
    chk("t3_r", remainder, 8'h34);

    // boundaries: divisor 1, small dividend over larger divisor
    launch(16'h8000, 8'd1);
    wait_done(n);
    chk("t6_q", quotient, 16'h8000);
    chk("t6_r", remainder, 0);
    chk("t6_dbz", div_by_zero, 0);
    launch(16'd255, 8'd16);
    wait_done(n);
    chk("t7_q", quotient, 15);
    chk("t7_r", remainder, 15);

    // start pulsed at E5 with different operands must be ignored
    launch(16'd50000, 8'd3);
    repeat (4) @(posedge clk);
    #1;
    dividend = 16'd9; divisor = 8'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(n);
    chk("t4_lat", n, 11);
    chk("t4_q", quotient, 16666);
    chk("t4_r", remainder, 2);
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    chk("t4_no_extra_done", seen, 0);
    chk("t4_q_hold", quotient, 16666);

    // asynchronous reset mid-division
    launch(16'd1000, 8'd7);
    repeat (7) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    chk("t5_q", quotient, 0);
    chk("t5_r", remainder, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    launch(16'd100, 8'd10);
    wait_done(n);
    chk("t5b_lat", n, 16);
    chk("t5b_q", quotient, 10);
    chk("t5b_r", remainder, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
